sram_denetleyici: RTL and testbench

- Two-port front end for the single-port `pdk_sram` macro.
- Two requesters share the one SRAM:
  - port 0: instruction fetch side.
  - port 1: data/memory side.
- Block duties:
  - Arbitrates between the two ports round-robin.
  - Runs the macro's pulse-style CE protocol: setup, CE rising edge, then output-enable capture.
  - Returns read data and write acknowledges with a fixed latency.

---
 rtl/sram_denetleyici.sv | 188 ++++++++++++++++++
 tb/tb_sram_denetleyici.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_denetleyici.sv
// Two-port round-robin front end for the single-port pdk_sram macro with the pulse-style CE protocol.
// Optional byte-masked writes (read-modify-write) are enabled with `define SRAM_BAYT_MASKE_EN.
module sram_denetleyici #(
  parameter  int SATIR_SAYISI     = 64,
  parameter  int SOZCUK_GENISLIGI = 32,
  localparam int ADRES_GENISLIGI  = $clog2(SATIR_SAYISI),
  localparam int BAYT_SAYISI      = SOZCUK_GENISLIGI / 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        p0_istek_gecerli_i,
  output logic                        p0_istek_hazir_o,
  input  logic                        p0_yaz_i,
  input  logic [ADRES_GENISLIGI-1:0]  p0_adres_i,
  input  logic [SOZCUK_GENISLIGI-1:0] p0_veri_i,
  input  logic [BAYT_SAYISI-1:0]      p0_maske_i,
  output logic                        p0_yanit_gecerli_o,
  output logic [SOZCUK_GENISLIGI-1:0] p0_veri_o,
  input  logic                        p1_istek_gecerli_i,
  output logic                        p1_istek_hazir_o,
  input  logic                        p1_yaz_i,
  input  logic [ADRES_GENISLIGI-1:0]  p1_adres_i,
  input  logic [SOZCUK_GENISLIGI-1:0] p1_veri_i,
  input  logic [BAYT_SAYISI-1:0]      p1_maske_i,
  output logic                        p1_yanit_gecerli_o,
  output logic [SOZCUK_GENISLIGI-1:0] p1_veri_o,
  output logic                        sram_ce_o,
  output logic                        sram_web_o,
  output logic                        sram_oeb_o,
  output logic                        sram_csb_o,
  output logic [ADRES_GENISLIGI-1:0]  sram_a_o,
  output logic [SOZCUK_GENISLIGI-1:0] sram_i_o,
  input  logic [SOZCUK_GENISLIGI-1:0] sram_o_i
);

  typedef enum logic [2:0] {BOSTA, KUR, TETIK, YAKALA, BITIR} durum_t;

  durum_t durum;
  logic   son_secim;
  logic   sahip;
  logic   secim;
  logic   secim_var;
  logic                        sec_yaz;
  logic [ADRES_GENISLIGI-1:0]  sec_adres;
  logic [SOZCUK_GENISLIGI-1:0] sec_veri;

`ifdef SRAM_BAYT_MASKE_EN
  logic [BAYT_SAYISI-1:0] sec_maske;
  logic [BAYT_SAYISI-1:0] maske;
  logic                   rmw;

  assign sec_maske = secim ? p1_maske_i : p0_maske_i;

  function automatic logic [SOZCUK_GENISLIGI-1:0] birlestir(
    input logic [SOZCUK_GENISLIGI-1:0] eski,
    input logic [SOZCUK_GENISLIGI-1:0] yeni,
    input logic [BAYT_SAYISI-1:0]      m
  );
    logic [SOZCUK_GENISLIGI-1:0] sonuc;
    for (int k = 0; k < BAYT_SAYISI; k++)
      sonuc[8*k +: 8] = m[k] ? yeni[8*k +: 8] : eski[8*k +: 8];
    return sonuc;
  endfunction
`else
  logic unused_maske;
  assign unused_maske = ^{p0_maske_i, p1_maske_i};
`endif

  // Grant only while idle; on a tie the port that lost last time wins.
  always_comb begin
    secim_var = 1'b0;
    secim     = 1'b0;
    if (durum == BOSTA) begin
      if (p0_istek_gecerli_i && p1_istek_gecerli_i) begin
        secim_var = 1'b1;
        secim     = ~son_secim;
      end else if (p0_istek_gecerli_i) begin
        secim_var = 1'b1;
      end else if (p1_istek_gecerli_i) begin
        secim_var = 1'b1;
        secim     = 1'b1;
      end
    end
  end

  assign p0_istek_hazir_o = secim_var & ~secim;
  assign p1_istek_hazir_o = secim_var & secim;
  assign sec_yaz   = secim ? p1_yaz_i   : p0_yaz_i;
  assign sec_adres = secim ? p1_adres_i : p0_adres_i;
  assign sec_veri  = secim ? p1_veri_i  : p0_veri_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum              <= BOSTA;
      son_secim          <= 1'b1;
      sahip              <= 1'b0;
      sram_ce_o          <= 1'b0;
      sram_csb_o         <= 1'b1;
      sram_web_o         <= 1'b1;
      sram_oeb_o         <= 1'b1;
      sram_a_o           <= '0;
      sram_i_o           <= '0;
      p0_yanit_gecerli_o <= 1'b0;
      p1_yanit_gecerli_o <= 1'b0;
      p0_veri_o          <= '0;
      p1_veri_o          <= '0;
`ifdef SRAM_BAYT_MASKE_EN
      rmw                <= 1'b0;
`endif
    end else begin
      p0_yanit_gecerli_o <= 1'b0;
      p1_yanit_gecerli_o <= 1'b0;
      case (durum)
        BOSTA: begin
          if (secim_var) begin
            sahip     <= secim;
            son_secim <= secim;
            sram_a_o  <= sec_adres;
            sram_i_o  <= sec_veri;
`ifdef SRAM_BAYT_MASKE_EN
            maske <= sec_maske;
            if (sec_yaz && (sec_maske == '0)) begin
              // Nothing to write: acknowledge immediately without touching the macro.
              p0_yanit_gecerli_o <= ~secim;
              p1_yanit_gecerli_o <= secim;
            end else begin
              sram_csb_o <= 1'b0;
              // A partial mask starts with a read of the old word.
              sram_web_o <= ~(sec_yaz && (sec_maske == '1));
              rmw        <= sec_yaz && (sec_maske != '1);
              durum      <= KUR;
            end
`else
            sram_csb_o <= 1'b0;
            sram_web_o <= ~sec_yaz;
            durum      <= KUR;
`endif
          end
        end
        KUR: begin
          sram_ce_o <= 1'b1;
          durum     <= TETIK;
        end
        TETIK: begin
          sram_ce_o <= 1'b0;
          if (sram_web_o) begin
            sram_oeb_o <= 1'b0;
            durum      <= YAKALA;
          end else begin
            durum <= BITIR;
          end
        end
        YAKALA: begin
          sram_oeb_o <= 1'b1;
`ifdef SRAM_BAYT_MASKE_EN
          if (rmw) begin
            sram_i_o   <= birlestir(sram_o_i, sram_i_o, maske);
            sram_web_o <= 1'b0;
            rmw        <= 1'b0;
            durum      <= KUR;
          end else
`endif
          begin
            if (sahip) begin
              p1_veri_o          <= sram_o_i;
              p1_yanit_gecerli_o <= 1'b1;
            end else begin
              p0_veri_o          <= sram_o_i;
              p0_yanit_gecerli_o <= 1'b1;
            end
            sram_csb_o <= 1'b1;
            sram_web_o <= 1'b1;
            durum      <= BOSTA;
          end
        end
        BITIR: begin
          p0_yanit_gecerli_o <= ~sahip;
          p1_yanit_gecerli_o <= sahip;
          sram_csb_o         <= 1'b1;
          sram_web_o         <= 1'b1;
          durum              <= BOSTA;
        end
        default: durum <= BOSTA;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_denetleyici.sv
// Directed bench for sram_denetleyici with a behavioural pdk_sram model that acts on CE rising edges.
module tb_sram_denetleyici;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        p0_istek_gecerli_i, p0_istek_hazir_o, p0_yaz_i, p0_yanit_gecerli_o;
  logic [5:0]  p0_adres_i;
  logic [31:0] p0_veri_i, p0_veri_o;
  logic [3:0]  p0_maske_i;
  logic        p1_istek_gecerli_i, p1_istek_hazir_o, p1_yaz_i, p1_yanit_gecerli_o;
  logic [5:0]  p1_adres_i;
  logic [31:0] p1_veri_i, p1_veri_o;
  logic [3:0]  p1_maske_i;
  logic        sram_ce_o, sram_web_o, sram_oeb_o, sram_csb_o;
  logic [5:0]  sram_a_o;
  logic [31:0] sram_i_o, sram_o_i;

  int toplam = 0;
  int gecen  = 0;

  sram_denetleyici dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p0_istek_gecerli_i(p0_istek_gecerli_i), .p0_istek_hazir_o(p0_istek_hazir_o),
    .p0_yaz_i(p0_yaz_i), .p0_adres_i(p0_adres_i), .p0_veri_i(p0_veri_i), .p0_maske_i(p0_maske_i),
    .p0_yanit_gecerli_o(p0_yanit_gecerli_o), .p0_veri_o(p0_veri_o),
    .p1_istek_gecerli_i(p1_istek_gecerli_i), .p1_istek_hazir_o(p1_istek_hazir_o),
    .p1_yaz_i(p1_yaz_i), .p1_adres_i(p1_adres_i), .p1_veri_i(p1_veri_i), .p1_maske_i(p1_maske_i),
    .p1_yanit_gecerli_o(p1_yanit_gecerli_o), .p1_veri_o(p1_veri_o),
    .sram_ce_o(sram_ce_o), .sram_web_o(sram_web_o), .sram_oeb_o(sram_oeb_o), .sram_csb_o(sram_csb_o),
    .sram_a_o(sram_a_o), .sram_i_o(sram_i_o), .sram_o_i(sram_o_i)
  );

  always #5 clk_i = ~clk_i;

  // Macro model: access on CE rising edge, read data driven while OEB is low.
  logic [31:0] mem [64];
  logic [31:0] dout = 32'h0;
  always @(posedge sram_ce_o) begin
    if (!sram_csb_o) begin
      if (!sram_web_o) mem[sram_a_o] <= sram_i_o;
      else             dout <= mem[sram_a_o];
    end
  end
  assign sram_o_i = sram_oeb_o ? 32'h0 : dout;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    toplam++;
    if (gozlenen === beklenen) gecen++;
    else $display("FAIL %s: got %h expected %h", etiket, gozlenen, beklenen);
  endtask

  task automatic kenar;
    @(posedge clk_i);
    #1;
  endtask

  task automatic orta;
    @(negedge clk_i);
  endtask

  task automatic surucu(input int port, input logic g, input logic y, input logic [5:0] a,
                        input logic [31:0] d, input logic [3:0] m);
    if (port == 0) begin
      p0_istek_gecerli_i = g; p0_yaz_i = y; p0_adres_i = a; p0_veri_i = d; p0_maske_i = m;
    end else begin
      p1_istek_gecerli_i = g; p1_yaz_i = y; p1_adres_i = a; p1_veri_i = d; p1_maske_i = m;
    end
  endtask

  // One isolated access; entered at the start of an idle cycle, returns at the start of cycle 5.
  task automatic tek_erisim(input int port, input logic y, input logic [5:0] a,
                            input logic [31:0] d, input logic [31:0] bek, input logic [3:0] m);
    logic [31:0] diger;
    logic        web_bek, oeb_bek;
    web_bek = ~y;
    oeb_bek = y;
    diger   = (port == 0) ? p1_veri_o : p0_veri_o;
    surucu(port, 1'b1, y, a, d, m);
    orta;
    kontrol("hazir", (port == 0) ? p0_istek_hazir_o : p1_istek_hazir_o, 32'd1);
    kontrol("hazir_diger", (port == 0) ? p1_istek_hazir_o : p0_istek_hazir_o, 32'd0);
    kenar;
    surucu(port, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
    orta;
    kontrol("kur_ce", sram_ce_o, 32'd0);
    kontrol("kur_csb", sram_csb_o, 32'd0);
    kontrol("kur_web", sram_web_o, web_bek);
    kontrol("kur_a", sram_a_o, a);
    if (y) kontrol("kur_i", sram_i_o, d);
    kenar; orta;
    kontrol("tetik_ce", sram_ce_o, 32'd1);
    kontrol("tetik_a", sram_a_o, a);
    kontrol("tetik_web", sram_web_o, web_bek);
    kenar; orta;
    kontrol("c3_ce", sram_ce_o, 32'd0);
    kontrol("c3_oeb", sram_oeb_o, oeb_bek);
    kontrol("c3_csb", sram_csb_o, 32'd0);
    kenar; orta;
    kontrol("yanit", (port == 0) ? p0_yanit_gecerli_o : p1_yanit_gecerli_o, 32'd1);
    kontrol("yanit_diger", (port == 0) ? p1_yanit_gecerli_o : p0_yanit_gecerli_o, 32'd0);
    if (!y) kontrol("okuma_veri", (port == 0) ? p0_veri_o : p1_veri_o, bek);
    kontrol("diger_veri", (port == 0) ? p1_veri_o : p0_veri_o, diger);
    kontrol("c4_csb", sram_csb_o, 32'd1);
    kenar;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    surucu(0, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
    surucu(1, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
    kenar;
    orta;
    kontrol("rst_ce", sram_ce_o, 32'd0);
    kontrol("rst_csb", sram_csb_o, 32'd1);
    kontrol("rst_web", sram_web_o, 32'd1);
    kontrol("rst_oeb", sram_oeb_o, 32'd1);
    kontrol("rst_a", sram_a_o, 32'd0);
    kontrol("rst_i", sram_i_o, 32'd0);
    kontrol("rst_yanit0", p0_yanit_gecerli_o, 32'd0);
    kontrol("rst_yanit1", p1_yanit_gecerli_o, 32'd0);
    kontrol("rst_veri0", p0_veri_o, 32'h0);
    kontrol("rst_veri1", p1_veri_o, 32'h0);
    kenar;
    rst_i = 1'b0;

    // Write then read back on port 0.
    tek_erisim(0, 1'b1, 6'd5, 32'hDEADBEEF, 32'h0, 4'hF);
    orta;
    kontrol("yanit_tek_vuru", p0_yanit_gecerli_o, 32'd0);
    kenar;
    tek_erisim(0, 1'b0, 6'd5, 32'h0, 32'hDEADBEEF, 4'hF);
    tek_erisim(0, 1'b1, 6'd2, 32'hB2B2B2B2, 32'h0, 4'hF);
    tek_erisim(1, 1'b1, 6'd1, 32'hA1A1A1A1, 32'h0, 4'hF);

    // Both ports valid continuously: p0 reads addr 1, p1 reads addr 2.
    surucu(0, 1'b1, 1'b0, 6'd1, 32'h0, 4'hF);
    surucu(1, 1'b1, 1'b0, 6'd2, 32'h0, 4'hF);
    for (int c = 0; c <= 16; c++) begin
      logic e0, e1;
      int   sahip_b;
      orta;
      e0 = (c % 4 == 0) && (c < 16) && ((c / 4) % 2 == 0);
      e1 = (c % 4 == 0) && (c < 16) && ((c / 4) % 2 == 1);
      kontrol("arb_hazir0", p0_istek_hazir_o, e0);
      kontrol("arb_hazir1", p1_istek_hazir_o, e1);
      if (c >= 4 && c % 4 == 0) begin
        sahip_b = (c / 4 - 1) % 2;
        kontrol("arb_yanit0", p0_yanit_gecerli_o, sahip_b == 0);
        kontrol("arb_yanit1", p1_yanit_gecerli_o, sahip_b == 1);
        if (sahip_b == 0) begin
          kontrol("arb_veri0", p0_veri_o, 32'hA1A1A1A1);
          kontrol("arb_veri1_sabit", p1_veri_o, (c == 4) ? 32'h0 : 32'hB2B2B2B2);
        end else begin
          kontrol("arb_veri1", p1_veri_o, 32'hB2B2B2B2);
          kontrol("arb_veri0_sabit", p0_veri_o, 32'hA1A1A1A1);
        end
      end
      kenar;
      if (c == 12) begin
        surucu(0, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
        surucu(1, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
      end
    end

    // Back-to-back: port 1 waits and is taken in port 0's response cycle.
    surucu(0, 1'b1, 1'b0, 6'd5, 32'h0, 4'hF);
    orta;
    kontrol("b2b_hazir0", p0_istek_hazir_o, 32'd1);
    kenar;
    surucu(0, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
    kenar;
    surucu(1, 1'b1, 1'b1, 6'd7, 32'h77777777, 4'hF);
    orta;
    kontrol("b2b_bekle", p1_istek_hazir_o, 32'd0);
    kenar; kenar; orta;
    kontrol("b2b_yanit0", p0_yanit_gecerli_o, 32'd1);
    kontrol("b2b_veri0", p0_veri_o, 32'hDEADBEEF);
    kontrol("b2b_hazir1", p1_istek_hazir_o, 32'd1);
    kenar;
    surucu(1, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
    orta;
    kontrol("b2b_c5_ce", sram_ce_o, 32'd0);
    kenar; orta;
    kontrol("b2b_c6_ce", sram_ce_o, 32'd1);
    kontrol("b2b_c6_a", sram_a_o, 32'd7);
    kenar; kenar; orta;
    kontrol("b2b_yanit1", p1_yanit_gecerli_o, 32'd1);
    kontrol("b2b_yanit0_yok", p0_yanit_gecerli_o, 32'd0);
    kenar;
    tek_erisim(1, 1'b0, 6'd7, 32'h0, 32'h77777777, 4'hF);

    // Reset during TETIK of a read.
    surucu(0, 1'b1, 1'b0, 6'd5, 32'h0, 4'hF);
    orta;
    kontrol("rstm_kabul", p0_istek_hazir_o, 32'd1);
    kenar;
    surucu(0, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
    kenar;
    rst_i = 1'b1;
    orta;
    kontrol("rstm_tetik_ce", sram_ce_o, 32'd1);
    kenar; orta;
    kontrol("rstm_ce", sram_ce_o, 32'd0);
    kontrol("rstm_csb", sram_csb_o, 32'd1);
    kontrol("rstm_web", sram_web_o, 32'd1);
    kontrol("rstm_oeb", sram_oeb_o, 32'd1);
    kontrol("rstm_a", sram_a_o, 32'd0);
    kontrol("rstm_i", sram_i_o, 32'd0);
    kontrol("rstm_yanit0", p0_yanit_gecerli_o, 32'd0);
    kontrol("rstm_veri0", p0_veri_o, 32'h0);
    kenar;
    rst_i = 1'b0;
    surucu(0, 1'b1, 1'b0, 6'd5, 32'h0, 4'hF);
    surucu(1, 1'b1, 1'b0, 6'd7, 32'h0, 4'hF);
    orta;
    kontrol("rstm_yanit_yok", p0_yanit_gecerli_o, 32'd0);
    kontrol("rstm_esit_hazir0", p0_istek_hazir_o, 32'd1);
    kontrol("rstm_esit_hazir1", p1_istek_hazir_o, 32'd0);
    kenar;
    surucu(0, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
    surucu(1, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
    repeat (3) kenar;
    orta;
    kontrol("rstm_son_yanit0", p0_yanit_gecerli_o, 32'd1);
    kontrol("rstm_son_veri0", p0_veri_o, 32'hDEADBEEF);
    kontrol("rstm_son_yanit1", p1_yanit_gecerli_o, 32'd0);
    kenar;

`ifdef SRAM_BAYT_MASKE_EN
    begin
      int n, ce_say;
      surucu(1, 1'b1, 1'b1, 6'd5, 32'h11223344, 4'b0101);
      orta;
      kontrol("rmw_hazir", p1_istek_hazir_o, 32'd1);
      kenar;
      surucu(1, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
      n = 0;
      ce_say = 0;
      for (int k = 1; k <= 10; k++) begin
        orta;
        if (sram_ce_o) ce_say++;
        if (p1_yanit_gecerli_o && n == 0) n = k;
        kenar;
      end
      kontrol("rmw_gecikme", n, 32'd7);
      kontrol("rmw_ce_sayisi", ce_say, 32'd2);
      tek_erisim(0, 1'b0, 6'd5, 32'h0, 32'hDE22BE44, 4'hF);
      surucu(0, 1'b1, 1'b1, 6'd6, 32'hFFFFFFFF, 4'h0);
      orta;
      kontrol("sifir_maske_hazir", p0_istek_hazir_o, 32'd1);
      kenar;
      surucu(0, 1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
      orta;
      kontrol("sifir_maske_yanit", p0_yanit_gecerli_o, 32'd1);
      kontrol("sifir_maske_ce1", sram_ce_o, 32'd0);
      kenar; orta;
      kontrol("sifir_maske_ce2", sram_ce_o, 32'd0);
      kontrol("sifir_maske_yanit_bitti", p0_yanit_gecerli_o, 32'd0);
      kenar;
    end
`else
    // Without the mask feature a partial strobe still writes the full word.
    tek_erisim(1, 1'b1, 6'd5, 32'h11223344, 32'h0, 4'b0101);
    tek_erisim(0, 1'b0, 6'd5, 32'h0, 32'h11223344, 4'hF);
`endif

    $display("%0d/%0d checks passed", gecen, toplam);
    $finish;
  end

endmodule
